// File: rtl/fire_expand_pkg.sv
// rtl/fire_expand_pkg.sv - shared types and defaults for the expand accumulator controller
package fire_expand_pkg;

    localparam int ADDR_W_DEF     = 11;
    localparam int ADDR_STEP_DEF  = 4;
    localparam int PIPE_DEPTH_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Per-stage control carried alongside the write address through the delay line
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic line;
    } stage_flags_t;

    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/fire_expand_wr_pipe.sv
// rtl/fire_expand_wr_pipe.sv - stalling delay line aligning write controls with the read-modify-write latency
module fire_expand_wr_pipe
    import fire_expand_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              adv_i,
    input  stage_flags_t      in_flags_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output stage_flags_t      out_flags_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    stage_flags_t      flags_q [PIPE_DEPTH];
    stage_flags_t      flags_d [PIPE_DEPTH];
    logic [ADDR_W-1:0] addr_q  [PIPE_DEPTH];
    logic [ADDR_W-1:0] addr_d  [PIPE_DEPTH];

    always_comb begin
        flags_d = flags_q;
        addr_d  = addr_q;
        if (clear_i) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                flags_d[i] = '0;
                addr_d[i]  = '0;
            end
        end else if (adv_i) begin
            flags_d[0] = in_flags_i;
            addr_d[0]  = in_addr_i;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                flags_d[i] = flags_q[i-1];
                addr_d[i]  = addr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                flags_q[i] <= '0;
                addr_q[i]  <= '0;
            end
        end else begin
            flags_q <= flags_d;
            addr_q  <= addr_d;
        end
    end

    assign out_flags_o = flags_q[PIPE_DEPTH-1];
    assign out_addr_o  = addr_q[PIPE_DEPTH-1];

endmodule

// File: rtl/fire_expand_acc_ctrl.sv
// rtl/fire_expand_acc_ctrl.sv - expand accumulator read/write controller; optional FIRE_EXP_PROTO_CHK_EN adds proto_err_o
module fire_expand_acc_ctrl
    import fire_expand_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ADDR_STEP  = ADDR_STEP_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              expand_flag_i,
    input  logic [ADDR_W-1:0] layer_end_addr_i,
    input  logic              new_layer_flag_i,
    input  logic              new_line_flag_i,
    input  logic              first_layer_flag_i,
    input  logic              last_layer_flag_i,
    input  logic              fire_end_flag_i,
    output logic              layer_done_flag_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_en_o,
    output logic              acc_zero_sel_o,
    output logic              out_valid_o,
    output logic              line_start_o,
    output logic              busy_o,
    output logic              fire_done_o
`ifdef FIRE_EXP_PROTO_CHK_EN
    ,
    output logic              proto_err_o
`endif
);

    localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              layer_done_q, layer_done_d;
    logic              fire_done_q, fire_done_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;

    logic              run_beat, drain_beat, addr_wrap, drain_last;
    stage_flags_t      pipe_in, pipe_out;
    logic [ADDR_W-1:0] pipe_out_addr;
    logic              wr_en;

    assign run_beat   = expand_flag_i & (state_q == ST_RUN);
    assign drain_beat = expand_flag_i & (state_q == ST_DRAIN);
    assign addr_wrap  = (rd_addr_q == layer_end_addr_i);
    assign drain_last = (drain_cnt_q == CNT_W'(PIPE_DEPTH - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (fire_end_flag_i) state_d = ST_DRAIN;
                ST_DRAIN: if (drain_beat && drain_last) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        wr_en          = pipe_out.valid & expand_flag_i & ~start_i;
        busy_o         = is_active(state_q);
        wr_en_o        = wr_en;
        wr_addr_o      = pipe_out_addr;
        acc_zero_sel_o = pipe_out.valid & pipe_out.first;
        out_valid_o    = wr_en & pipe_out.last;
        line_start_o   = wr_en & pipe_out.last & pipe_out.line;
    end

    // Read counter, done pulse and drain counter; start overrides any beat in the same cycle
    always_comb begin
        rd_addr_d    = rd_addr_q;
        layer_done_d = 1'b0;
        drain_cnt_d  = drain_cnt_q;
        fire_done_d  = fire_done_q;
        if (start_i) begin
            rd_addr_d   = '0;
            drain_cnt_d = '0;
            fire_done_d = 1'b0;
        end else begin
            if (run_beat) begin
                if (addr_wrap) begin
                    rd_addr_d    = '0;
                    layer_done_d = 1'b1;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(ADDR_STEP);
                end
            end
            if (state_q != ST_DRAIN) begin
                drain_cnt_d = '0;
            end else if (drain_beat) begin
                drain_cnt_d = drain_cnt_q + 1'b1;
            end
            if (state_q == ST_DRAIN && state_d == ST_DONE) begin
                fire_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_addr_q    <= '0;
            layer_done_q <= 1'b0;
            drain_cnt_q  <= '0;
            fire_done_q  <= 1'b0;
        end else begin
            rd_addr_q    <= rd_addr_d;
            layer_done_q <= layer_done_d;
            drain_cnt_q  <= drain_cnt_d;
            fire_done_q  <= fire_done_d;
        end
    end

    assign rd_addr_o         = rd_addr_q;
    assign layer_done_flag_o = layer_done_q;
    assign fire_done_o       = fire_done_q;

    assign pipe_in.valid = (state_q == ST_RUN);
    assign pipe_in.first = first_layer_flag_i;
    assign pipe_in.last  = last_layer_flag_i;
    assign pipe_in.line  = new_line_flag_i;

    fire_expand_wr_pipe #(
        .ADDR_W     (ADDR_W),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_wr_pipe (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (start_i),
        .adv_i       ((run_beat | drain_beat) & ~start_i),
        .in_flags_i  (pipe_in),
        .in_addr_i   (rd_addr_q),
        .out_flags_o (pipe_out),
        .out_addr_o  (pipe_out_addr)
    );

`ifdef FIRE_EXP_PROTO_CHK_EN
    logic proto_err_q, proto_err_d;
    logic line_wrap_q, line_wrap_d;

    // line_wrap tracks whether a layer range has already wrapped since the last row start
    always_comb begin
        proto_err_d = proto_err_q;
        line_wrap_d = line_wrap_q;
        if (start_i) begin
            proto_err_d = 1'b0;
            line_wrap_d = 1'b0;
        end else begin
            if (expand_flag_i && (state_q == ST_IDLE || state_q == ST_DONE)) proto_err_d = 1'b1;
            if (run_beat && new_layer_flag_i && rd_addr_q != '0) proto_err_d = 1'b1;
            if (run_beat && first_layer_flag_i && last_layer_flag_i &&
                layer_end_addr_i != '0 && line_wrap_q) proto_err_d = 1'b1;
            if (run_beat && new_line_flag_i) line_wrap_d = 1'b0;
            if (run_beat && addr_wrap) line_wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            proto_err_q <= 1'b0;
            line_wrap_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
            line_wrap_q <= line_wrap_d;
        end
    end

    assign proto_err_o = proto_err_q;
`else
    logic unused_new_layer;
    assign unused_new_layer = new_layer_flag_i;
`endif

endmodule

// File: tb/tb_fire_expand_acc_ctrl.sv
// tb/tb_fire_expand_acc_ctrl.sv - self-checking bench for fire_expand_acc_ctrl
module tb_fire_expand_acc_ctrl;

    localparam int AW   = 11;
    localparam int STEP = 4;
    localparam int PD   = 3;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          start_i, expand_flag_i, new_layer_flag_i, new_line_flag_i;
    logic          first_layer_flag_i, last_layer_flag_i, fire_end_flag_i;
    logic [AW-1:0] layer_end_addr_i;
    logic          layer_done_flag_o, wr_en_o, acc_zero_sel_o, out_valid_o;
    logic          line_start_o, busy_o, fire_done_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fire_expand_acc_ctrl #(.ADDR_W(AW), .ADDR_STEP(STEP), .PIPE_DEPTH(PD)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n_i),
        .start_i            (start_i),
        .expand_flag_i      (expand_flag_i),
        .layer_end_addr_i   (layer_end_addr_i),
        .new_layer_flag_i   (new_layer_flag_i),
        .new_line_flag_i    (new_line_flag_i),
        .first_layer_flag_i (first_layer_flag_i),
        .last_layer_flag_i  (last_layer_flag_i),
        .fire_end_flag_i    (fire_end_flag_i),
        .layer_done_flag_o  (layer_done_flag_o),
        .rd_addr_o          (rd_addr_o),
        .wr_addr_o          (wr_addr_o),
        .wr_en_o            (wr_en_o),
        .acc_zero_sel_o     (acc_zero_sel_o),
        .out_valid_o        (out_valid_o),
        .line_start_o       (line_start_o),
        .busy_o             (busy_o),
        .fire_done_o        (fire_done_o)
    );

    // Reference model: words queued in beat order, written PD beats after capture
    typedef struct {bit v; int addr; bit f; bit l; bit n;} ent_t;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
    int   m_mode, m_rd, m_drain_left;
    bit   m_pulse, m_done;
    ent_t m_words[$];

    typedef struct {
        bit st; bit ex; int ea; bit f; bit l; bit n; bit fe;
        int rd; bit ld; bit wr; int wa; bit zs; bit ov; bit ls;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_flush();
        m_words.delete();
        for (int i = 0; i < PD; i++) m_words.push_back('{0, 0, 0, 0, 0});
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_rd = 0; m_pulse = 0; m_done = 0; m_drain_left = 0;
        model_flush();
    endtask

    task automatic model_check();
        ent_t fr;
        bit   ew;
        fr = m_words[0];
        ew = fr.v && expand_flag_i && !start_i;
        chk("rd_addr", int'(rd_addr_o), m_rd);
        chk("layer_done", int'(layer_done_flag_o), int'(m_pulse));
        chk("busy", int'(busy_o), int'(m_mode == M_RUN || m_mode == M_DRAIN));
        chk("fire_done", int'(fire_done_o), int'(m_done));
        chk("wr_en", int'(wr_en_o), int'(ew));
        if (ew) chk("wr_addr", int'(wr_addr_o), fr.addr);
        chk("zero_sel", int'(acc_zero_sel_o), int'(fr.v && fr.f));
        chk("out_valid", int'(out_valid_o), int'(ew && fr.l));
        chk("line_start", int'(line_start_o), int'(ew && fr.l && fr.n));
    endtask

    task automatic model_step();
        if (start_i) begin
            m_mode = M_RUN; m_rd = 0; m_pulse = 0; m_done = 0;
            model_flush();
            return;
        end
        m_pulse = 0;
        if (expand_flag_i && (m_mode == M_RUN || m_mode == M_DRAIN)) begin
            void'(m_words.pop_front());
            m_words.push_back('{m_mode == M_RUN, m_rd, first_layer_flag_i,
                                last_layer_flag_i, new_line_flag_i});
        end
        if (expand_flag_i && m_mode == M_RUN) begin
            if (m_rd == int'(layer_end_addr_i)) begin
                m_rd = 0; m_pulse = 1;
            end else begin
                m_rd = (m_rd + STEP) % (1 << AW);
            end
        end
        if (m_mode == M_RUN && fire_end_flag_i) begin
            m_mode = M_DRAIN; m_drain_left = PD;
        end else if (m_mode == M_DRAIN && expand_flag_i) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_mode = M_DONE; m_done = 1;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit ex, input int ea,
                         input bit f, input bit l, input bit n, input bit fe);
        @(negedge clk);
        start_i = st; expand_flag_i = ex; layer_end_addr_i = AW'(ea);
        first_layer_flag_i = f; last_layer_flag_i = l; new_line_flag_i = n;
        fire_end_flag_i = fe; new_layer_flag_i = 1'b0;
        #1;
        model_check();
        model_step();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rd"}, int'(rd_addr_o), 0);
        chk({nm, "_ld"}, int'(layer_done_flag_o), 0);
        chk({nm, "_wr"}, int'(wr_en_o), 0);
        chk({nm, "_zs"}, int'(acc_zero_sel_o), 0);
        chk({nm, "_ov"}, int'(out_valid_o), 0);
        chk({nm, "_ls"}, int'(line_start_o), 0);
        chk({nm, "_busy"}, int'(busy_o), 0);
        chk({nm, "_fd"}, int'(fire_done_o), 0);
    endtask

    initial begin
        int ea_r;
        int ld_cnt;

        //          st ex ea f  l  n  fe | rd  ld wr wa zs ov ls
        tbl[0] = '{1, 0, 12, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 12, 1, 1, 1, 0,   0,  0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 12, 0, 1, 0, 0,   4,  0, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 12, 0, 0, 0, 0,   8,  0, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 1, 12, 0, 0, 0, 0,   12, 0, 1, 0, 1, 1, 1};
        tbl[5] = '{0, 0, 12, 0, 0, 0, 0,   0,  1, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 1, 12, 0, 0, 0, 0,   0,  0, 1, 4, 0, 1, 0};
        tbl[7] = '{0, 1, 12, 0, 0, 0, 0,   4,  0, 1, 8, 0, 0, 0};

        rst_n_i = 1'b0;
        start_i = 0; expand_flag_i = 0; layer_end_addr_i = '0; new_layer_flag_i = 0;
        new_line_flag_i = 0; first_layer_flag_i = 0; last_layer_flag_i = 0; fire_end_flag_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n_i = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].st, tbl[i].ex, tbl[i].ea, tbl[i].f, tbl[i].l, tbl[i].n, tbl[i].fe);
            chk($sformatf("tbl%0d_rd", i), int'(rd_addr_o), tbl[i].rd);
            chk($sformatf("tbl%0d_ld", i), int'(layer_done_flag_o), int'(tbl[i].ld));
            chk($sformatf("tbl%0d_wr", i), int'(wr_en_o), int'(tbl[i].wr));
            if (tbl[i].wr) chk($sformatf("tbl%0d_wa", i), int'(wr_addr_o), tbl[i].wa);
            chk($sformatf("tbl%0d_zs", i), int'(acc_zero_sel_o), int'(tbl[i].zs));
            chk($sformatf("tbl%0d_ov", i), int'(out_valid_o), int'(tbl[i].ov));
            chk($sformatf("tbl%0d_ls", i), int'(line_start_o), int'(tbl[i].ls));
        end

        // Fire end on the wrapping beat, then drain with idle gaps
        cycle(1, 0, 8, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) cycle(0, 1, 8, 0, 1, 0, b == 2);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("fe_last_run_pulse", int'(layer_done_flag_o), 1);
        chk("fe_busy", int'(busy_o), 1);
        ld_cnt = 0;
        for (int d = 0; d < 3; d++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 0, 0);
            ld_cnt += int'(layer_done_flag_o);
            chk($sformatf("drain%0d_busy", d), int'(busy_o), int'(d < 2));
            chk($sformatf("drain%0d_fire_done", d), int'(fire_done_o), int'(d == 2));
        end
        chk("drain_no_layer_done", ld_cnt, 0);
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("done_hold_rd", int'(rd_addr_o), 0);
        chk("done_hold_fd", int'(fire_done_o), 1);

        // Restart mid-run at rd_addr 8 with a full pipeline
        cycle(1, 0, 12, 0, 0, 0, 0);
        for (int b = 0; b < 6; b++) cycle(0, 1, 12, 1, 1, 0, 0);
        cycle(1, 1, 12, 1, 1, 0, 0);
        chk("restart_pre_rd", int'(rd_addr_o), 8);
        chk("restart_wr_gated", int'(wr_en_o), 0);
        for (int b = 0; b < 4; b++) begin
            cycle(0, 1, 12, 0, 0, 0, 0);
            chk($sformatf("restart_b%0d_wr", b), int'(wr_en_o), int'(b == 3));
        end

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        expand_flag_i = 1'b1;
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        start_i = 0; expand_flag_i = 0; fire_end_flag_i = 0;
        rst_n_i = 1'b1;

        // Randomized traffic with stalls, restarts and varying layer ranges
        ea_r = 12;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 5))
                    0: ea_r = 0;
                    1: ea_r = 4;
                    2: ea_r = 12;
                    3: ea_r = 28;
                    4: ea_r = 4 * $urandom_range(0, 15);
                    default: ea_r = $urandom_range(0, 2047);
                endcase
            end
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 9) < 6, ea_r,
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
